// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the fixed-latency line memory.
package dmem_pkg;
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned DEPTH   = 512;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LATENCY = 10;
    localparam int unsigned OFS_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;
endpackage

// File: rtl/data_memory.sv
// Off-chip line memory behind the data cache: one line read/write per request,
// completed by a one-cycle ack a fixed number of cycles after acceptance.
module data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned LINE_W  = dmem_pkg::LINE_W,
    parameter int unsigned DEPTH   = dmem_pkg::DEPTH,
    parameter int unsigned ADDR_W  = dmem_pkg::ADDR_W,
    parameter int unsigned LATENCY = dmem_pkg::LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);
    localparam int unsigned CNT_W = $clog2(LATENCY);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] wdata;
    logic              wr;
    logic              last_c;

    logic [LINE_W-1:0] memory [0:DEPTH-1];

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable_i) next_state = WAIT;
            WAIT:    if (last_c)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: ack and read data are combinational from the latched request
    always_comb begin
        last_c = (state == WAIT) && (count == CNT_W'(LATENCY - 1));
        ack_o  = last_c;
        data_o = last_c ? memory[idx] : '0;
    end

    // Request capture and latency counter; inputs are only sampled in IDLE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
            idx   <= '0;
            wdata <= '0;
            wr    <= 1'b0;
        end else if (state == IDLE) begin
            if (enable_i) begin
                count <= '0;
                idx   <= addr_i[OFS_W +: IDX_W];
                wdata <= data_i;
                wr    <= write_i;
            end
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // Array is never reset; a write commits only on the edge that ends the ack cycle
    always_ff @(posedge clk_i) begin
        if (last_c && wr) begin
            memory[idx] <= wdata;
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, hand-written
// corner sequences and randomized traffic against an array-based model.
module tb_data_memory;
    localparam int unsigned LW  = 256;
    localparam int unsigned LAT = 10;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [31:0]   addr_i;
    logic [LW-1:0] data_i;
    logic          enable_i;
    logic          write_i;
    logic          ack_o;
    logic [LW-1:0] data_o;

    data_memory dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    always #5 clk_i = ~clk_i;

    logic [LW-1:0] model [512];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   junk_addr;
    logic [LW-1:0] junk_data;

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] exp;
    } vec_t;

    vec_t vecs [7];

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % 512);
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge; returns read data and ack cycle (-1 on timeout)
    task automatic txn(input logic wr, input logic [31:0] a, input logic [LW-1:0] d,
                       output logic [LW-1:0] rd, output int lat);
        int  li;
        bit  stray;
        li    = line_of(a);
        stray = 1'b0;
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = a;
        data_i   = d;
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        write_i  = ~wr;
        addr_i   = junk_addr;
        data_i   = junk_data;
        lat = -1;
        rd  = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk_i);
            if (ack_o) begin
                lat = c;
                rd  = data_o;
                if (wr) chk("mem_before_ack_edge", dut.memory[li], model[li]);
                break;
            end
            if (data_o !== '0) stray = 1'b1;
        end
        chk("data_zero_while_waiting", LW'(stray), '0);
        if (lat < 0) begin
            $display("FAIL ack_timeout: got no ack expected ack at cycle %0d", LAT);
        end else begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk("ack_single_cycle", LW'(ack_o), '0);
        end
        if (wr) begin
            model[li] = d;
            chk("mem_after_write", dut.memory[li], d);
        end
    endtask

    logic [LW-1:0] l1, lecfa, lwrap, rd, exp;
    int            lat;
    int            ack_at [$];

    initial begin
        rst_i     = 1'b0;
        enable_i  = 1'b1;
        write_i   = 1'b0;
        addr_i    = 32'h20;
        data_i    = '0;
        junk_addr = 32'h0;
        junk_data = '0;
        l1    = {8{32'h8888_9999}};
        lecfa = {16{16'hECFA}};
        lwrap = {8{32'h1234_5A5A}};

        for (int i = 0; i < 512; i++) begin
            model[i] = rand_line();
            dut.memory[i] = model[i];
        end
        model[1] = l1;
        dut.memory[1] = l1;

        // Reset held with enable asserted: outputs quiet, nothing starts
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk("reset_ack", LW'(ack_o), '0);
            chk("reset_data", data_o, '0);
        end
        rst_i    = 1'b1;
        enable_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (ack_o) chk("no_txn_from_reset", LW'(ack_o), '0);
        end
        chk("post_reset_idle_ack", LW'(ack_o), '0);

        vecs[0] = '{1'b0, 32'h0000_0020, '0,    l1};
        vecs[1] = '{1'b1, 32'h0000_0040, lecfa, '0};
        vecs[2] = '{1'b0, 32'h0000_0040, '0,    lecfa};
        vecs[3] = '{1'b0, 32'h0000_003F, '0,    l1};
        vecs[4] = '{1'b0, 32'h0000_4020, '0,    l1};
        vecs[5] = '{1'b1, 32'h0000_3FE0, lwrap, '0};
        vecs[6] = '{1'b0, 32'h0000_7FE0, '0,    lwrap};

        for (int i = 0; i < 7; i++) begin
            junk_addr = $urandom;
            junk_data = rand_line();
            txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, lat);
            chk($sformatf("vec%0d_latency", i), LW'(lat), LW'(LAT));
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end

        // Inputs changed mid-transaction must not redirect the write
        junk_addr = 32'h200;
        junk_data = '0;
        exp = model[16];
        txn(1'b1, 32'h20, lecfa, rd, lat);
        chk("hold_latency", LW'(lat), LW'(LAT));
        chk("hold_line1", dut.memory[1], lecfa);
        chk("hold_line16", dut.memory[16], exp);

        // Enable left high through ack: exactly one re-accept in the following idle cycle
        enable_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 32'h20;
        @(posedge clk_i);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (ack_o) begin
                ack_at.push_back(c);
                chk($sformatf("b2b_rdata_c%0d", c), data_o, model[1]);
            end
            if (c == 21) enable_i = 1'b0;
        end
        chk("b2b_ack_count", LW'(ack_at.size()), LW'(2));
        if (ack_at.size() == 2) begin
            chk("b2b_first_ack", LW'(ack_at[0]), LW'(10));
            chk("b2b_second_ack", LW'(ack_at[1]), LW'(21));
        end

        // Reset at cycle 5 of a write aborts it and leaves the line untouched
        exp = model[3];
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'h60;
        data_i   = ~exp;
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk_i);
            if (c == 5) rst_i = 1'b0;
            if (c == 7) rst_i = 1'b1;
            if (ack_o) chk($sformatf("abort_no_ack_c%0d", c), LW'(ack_o), '0);
        end
        chk("abort_line_unchanged", dut.memory[3], exp);
        junk_addr = $urandom;
        junk_data = rand_line();
        txn(1'b0, 32'h60, '0, rd, lat);
        chk("abort_fresh_latency", LW'(lat), LW'(LAT));
        chk("abort_fresh_rdata", rd, exp);

        // Randomized traffic against the array model
        for (int i = 0; i < 40; i++) begin
            logic          w;
            logic [31:0]   a;
            logic [LW-1:0] d;
            w = 1'($urandom_range(0, 1));
            a = (i % 4 == 0) ? (32'($urandom_range(0, 3)) << 5) : $urandom;
            d = rand_line();
            junk_addr = $urandom;
            junk_data = rand_line();
            exp = model[line_of(a)];
            txn(w, a, d, rd, lat);
            chk($sformatf("rand%0d_latency", i), LW'(lat), LW'(LAT));
            if (!w) chk($sformatf("rand%0d_rdata", i), rd, exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
